// File: rtl/llki_key_loader.sv
// llki_key_loader: LLKI key-delivery initiator.
// Snapshots a KEY_WORDS x 64-bit key on a load command and streams it word by
// word over a valid/ready handshake, then waits for key-complete. A clear
// command pulses clear-key for one cycle and waits for the acknowledge.
// Every wait on the target is guarded by a saturating timeout counter.
module llki_key_loader #(
  parameter int KEY_WORDS = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_req,
  input  logic                      clear_req,
  input  logic [64*KEY_WORDS-1:0]   key_in,
  output logic                      busy,
  output logic                      load_done,
  output logic                      clear_done,
  output logic                      error,
  output logic [63:0]               llkid_key_data,
  output logic                      llkid_key_valid,
  input  logic                      llkid_key_ready,
  input  logic                      llkid_key_complete,
  output logic                      llkid_clear_key,
  input  logic                      llkid_clear_key_ack
);

  localparam int IDX_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(KEY_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_CMPL,
    CLEAR,
    WAIT_ACK
  } state_t;

  state_t           state;
  logic [63:0]      key_words [KEY_WORDS];
  logic [63:0]      snap      [KEY_WORDS];
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             timed_out;
  logic             xfer;

  // Split the flat key bus into words; word 0 is the least significant slice.
  generate
    for (genvar gi = 0; gi < KEY_WORDS; gi++) begin : g_key_words
      assign key_words[gi] = key_in[64*gi +: 64];
    end
  endgenerate

  // Saturating wait-cycle count and the timeout decision for this edge.
  always_comb begin
    cnt_inc   = (cnt == CNT_LIMIT) ? cnt : cnt + CNT_ONE;
    timed_out = (cnt_inc == CNT_LIMIT);
    xfer      = llkid_key_valid && llkid_key_ready;
  end

  // Main control FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      busy            <= 1'b0;
      load_done       <= 1'b0;
      clear_done      <= 1'b0;
      error           <= 1'b0;
      llkid_key_data  <= '0;
      llkid_key_valid <= 1'b0;
      llkid_clear_key <= 1'b0;
      idx             <= '0;
      cnt             <= '0;
      for (int i = 0; i < KEY_WORDS; i++) begin
        snap[i] <= '0;
      end
    end else begin
      // Done pulses and clear-key are single-cycle unless re-asserted below.
      load_done       <= 1'b0;
      clear_done      <= 1'b0;
      llkid_clear_key <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          // Clear has priority; the simultaneous load is simply dropped.
          if (clear_req) begin
            state           <= CLEAR;
            busy            <= 1'b1;
            error           <= 1'b0;
            llkid_clear_key <= 1'b1;
          end else if (load_req) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
              snap[i] <= key_words[i];
            end
            state           <= SEND;
            busy            <= 1'b1;
            error           <= 1'b0;
            idx             <= '0;
            llkid_key_data  <= key_words[0];
            llkid_key_valid <= 1'b1;
          end
        end

        SEND: begin
          if (xfer) begin
            // Each accepted word restarts the wait budget for the next one.
            cnt <= '0;
            if (idx == LAST_IDX) begin
              state           <= WAIT_CMPL;
              llkid_key_valid <= 1'b0;
            end else begin
              idx            <= idx + IDX_ONE;
              llkid_key_data <= snap[idx + IDX_ONE];
            end
          end else if (timed_out) begin
            state           <= IDLE;
            busy            <= 1'b0;
            error           <= 1'b1;
            llkid_key_valid <= 1'b0;
            cnt             <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        WAIT_CMPL: begin
          if (llkid_key_complete) begin
            state     <= IDLE;
            busy      <= 1'b0;
            load_done <= 1'b1;
            cnt       <= '0;
          end else if (timed_out) begin
            state <= IDLE;
            busy  <= 1'b0;
            error <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        CLEAR: begin
          // clear-key was raised on entry and drops here after one cycle.
          state <= WAIT_ACK;
          cnt   <= '0;
        end

        WAIT_ACK: begin
          if (llkid_clear_key_ack) begin
            // The target key is gone, so leave no copy of it behind here either.
            for (int i = 0; i < KEY_WORDS; i++) begin
              snap[i] <= '0;
            end
            llkid_key_data <= '0;
            state          <= IDLE;
            busy           <= 1'b0;
            clear_done     <= 1'b1;
            cnt            <= '0;
          end else if (timed_out) begin
            state <= IDLE;
            busy  <= 1'b0;
            error <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: begin
          state           <= IDLE;
          busy            <= 1'b0;
          llkid_key_valid <= 1'b0;
          cnt             <= '0;
        end
      endcase
    end
  end

endmodule
